// File: rtl/io_word_packer.sv
// Packs a serial receiver's byte stream into 32-bit words for the io_hub command parser.
// Framing errors and inter-byte timeouts discard the partial word so the parser never misaligns.
module io_word_packer #(
    parameter int BIG_ENDIAN     = 0,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_byte,
    input  logic             rx_err,
    output logic             dready,
    output logic [31:0]      dout,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt,
    output logic [7:0]       drop_cnt
);

    typedef enum logic {IDLE, COLLECT} state_t;

    localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    logic [1:0]       idx_q;
    logic [31:0]      shift_q;
    logic [31:0]      shift_d;
    logic [23:0]      tmo_q;
    logic             dready_q;
    logic [31:0]      dout_q;
    logic [CNT_W-1:0] word_cnt_q;
    logic [7:0]       drop_cnt_q;
    logic [1:0]       lane;
    logic             accept;

    assign accept = rx_valid && !rx_err;

    // Big-endian mode mirrors the lane order so the first byte lands in the top lane.
    assign lane = (BIG_ENDIAN != 0) ? ~idx_q : idx_q;

    always_comb begin
        shift_d = shift_q;
        case (lane)
            2'd0:    shift_d[7:0]   = rx_byte;
            2'd1:    shift_d[15:8]  = rx_byte;
            2'd2:    shift_d[23:16] = rx_byte;
            default: shift_d[31:24] = rx_byte;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            shift_q    <= 32'd0;
            tmo_q      <= 24'd0;
            dready_q   <= 1'b0;
            dout_q     <= 32'd0;
            word_cnt_q <= '0;
            drop_cnt_q <= 8'd0;
        end else begin
            dready_q <= 1'b0;
            if (accept) begin
                shift_q <= shift_d;
                tmo_q   <= 24'd0;
                if (idx_q == 2'd3) begin
                    dout_q     <= shift_d;
                    dready_q   <= 1'b1;
                    word_cnt_q <= word_cnt_q + CNT_W'(1);
                    idx_q      <= 2'd0;
                    state_q    <= IDLE;
                end else begin
                    idx_q   <= idx_q + 2'd1;
                    state_q <= COLLECT;
                end
            end else if (rx_valid) begin
                // An errored byte in IDLE has nothing to drop and leaves drop_cnt alone.
                if (state_q == COLLECT && drop_cnt_q != 8'hFF) begin
                    drop_cnt_q <= drop_cnt_q + 8'd1;
                end
                idx_q   <= 2'd0;
                tmo_q   <= 24'd0;
                state_q <= IDLE;
            end else if (state_q == COLLECT) begin
                if (tmo_q == TO_LAST) begin
                    if (drop_cnt_q != 8'hFF) begin
                        drop_cnt_q <= drop_cnt_q + 8'd1;
                    end
                    idx_q   <= 2'd0;
                    tmo_q   <= 24'd0;
                    state_q <= IDLE;
                end else begin
                    tmo_q <= tmo_q + 24'd1;
                end
            end
        end
    end

    assign dready   = dready_q;
    assign dout     = dout_q;
    assign busy     = (state_q == COLLECT);
    assign word_cnt = word_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/io_word_packer.md
Name: io_word_packer

Overview:
- Upstream neighbour of the io_hub command parser.
- Packs the serial receiver's byte stream into 32-bit words.
- Presents each word with a one-cycle dready pulse, which the parser samples to decode commands, addresses and data.
- Handles framing errors and inter-byte timeouts so that a broken transfer never leaves the parser misaligned.

Parameters:
- BIG_ENDIAN, 0: 0 = first byte received goes to dout[7:0]; 1 = first byte goes to dout[31:24].
- TIMEOUT_CYCLES, 100000: idle clocks allowed between bytes of one word before the partial word is dropped; legal range 2..2^24-1.
- CNT_W, 16: width of word_cnt.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_valid  in  1  rx_byte valid this cycle
- rx_byte  in  8  received byte
- rx_err  in  1  framing/parity error on current byte, qualified by rx_valid
- dready  out  1  one-cycle pulse, dout holds a complete word
- dout  out  32  assembled word; holds its value until the next pulse
- busy  out  1  partial word in progress (1 to 3 bytes held)
- word_cnt  out  CNT_W  words emitted; wraps modulo 2^CNT_W
- drop_cnt  out  8  partial words discarded; saturates at 255

Behaviour:
- Interface: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values: all outputs 0 (dready, dout, busy, word_cnt, drop_cnt); state IDLE, byte index 0, shift register 0, timeout counter 0.
- Reset mid-word: the partial word is discarded without incrementing drop_cnt.
- States:
  - IDLE: idx=0.
  - COLLECT: idx=1..3.
  - busy = (state==COLLECT).
- Accepted byte: a cycle with rx_valid=1 and rx_err=0.
  - The byte is placed in lane idx: LE lane idx = bits [8*idx+7:8*idx]; BE lane = bits [31-8*idx:24-8*idx].
  - idx increments.
- Fourth byte (idx==3) accepted in cycle N:
  - In cycle N+1, dout = assembled word and dready = 1.
  - Also in cycle N+1, word_cnt increments.
  - Also from cycle N+1, state is IDLE and idx = 0.
  - dready is registered, so latency from last byte to dready is 1 clock.
  - dready is high for exactly one cycle per word.
- Back-to-back bytes every cycle are supported. The word pulse overlaps collection of the next word; the next word's first byte in cycle N+1 is accepted normally.
- Error: rx_valid=1 and rx_err=1.
  - The byte is discarded.
  - If in COLLECT: the partial word is discarded, drop_cnt increments (saturating), and the state goes to IDLE.
  - If in IDLE: the byte is ignored and drop_cnt is unchanged.
  - dout and dready are never affected by an error.
- Timeout, active only in COLLECT:
  - The counter clears on every accepted byte and increments on every cycle without rx_valid.
  - When the counter reaches TIMEOUT_CYCLES-1 with no rx_valid: discard the partial word, drop_cnt++, go to IDLE, clear the counter.
  - Expiry cycle with rx_valid=1 and rx_err=0: the byte wins; it is accepted and the counter clears.
  - Expiry cycle with rx_err=1: the error path applies, so drop_cnt is incremented once only.
- Counter wrap rules:
  - drop_cnt holds at 255 once reached.
  - word_cnt wraps from 2^CNT_W-1 to 0.
- Unused lanes:
  - The shift register is not cleared between words; all four lanes are overwritten before emission.
  - dout updates only on the emission cycle.
- rx_byte is ignored when rx_valid=0.

Test Plan:
- Reset, then LE (BIG_ENDIAN=0), bytes 03,00,00,00 on consecutive cycles → one cycle after the 4th byte: dready=1, dout=32'h00000003, word_cnt=1; busy=1 during bytes 2-4, busy=0 after.
- Back-to-back stream of 8 bytes 11,22,33,44,55,66,77,88 at one per cycle → two dready pulses 4 cycles apart, dout=32'h44332211 then 32'h88776655; with BIG_ENDIAN=1 → 32'h11223344 then 32'h55667788.
- Bytes AA,BB, then a byte with rx_err=1, then 01,02,03,04 → drop_cnt=1, no pulse for the broken word, then dready with dout=32'h04030201; error in IDLE → drop_cnt unchanged.
- TIMEOUT_CYCLES=10: byte AA, silence 10 cycles → drop_cnt=1, busy=0. Repeat with a byte landing on the expiry cycle → byte accepted, drop_cnt unchanged, and the word completes normally.
- rst asserted after 2 bytes → all outputs 0 next cycle, drop_cnt=0. Separately, 300 induced drops → drop_cnt=255. Force word_cnt to 2^CNT_W-1 and emit one word → word_cnt=0.
